// File: rtl/csd_pkg.sv
// Shared CSD definitions: digit codes and default widths common to the
// binary-to-CSD converter and its consumers.
package csd_pkg;

    localparam logic [1:0] CSD_ZERO = 2'b00;
    localparam logic [1:0] CSD_POS  = 2'b01;
    localparam logic [1:0] CSD_NEG  = 2'b11;
    localparam logic [1:0] CSD_RSVD = 2'b10;

    localparam int unsigned CSD_DIGITS = 17;
    localparam int unsigned CSD_DATA_W = 16;

endpackage

// File: rtl/csd_shift_add_mac_if.sv
// Start/result bus of one CSD shift-add MAC row lane.
interface csd_shift_add_mac_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DIGITS = 17,
    parameter int unsigned ACC_W  = 40
);
    logic                     start;
    logic signed [DATA_W-1:0] x;
    logic [2*DIGITS-1:0]      csd;
    logic                     acc_clr;
    logic                     ready;
    logic                     done;
    logic signed [ACC_W-1:0]  acc_out;
    logic                     ovf;
    logic                     err;

    modport master (
        output start, x, csd, acc_clr,
        input  ready, done, acc_out, ovf, err
    );

    modport slave (
        input  start, x, csd, acc_clr,
        output ready, done, acc_out, ovf, err
    );
endinterface

// File: rtl/csd_digit_addsub.sv
// One CSD digit step: adds, subtracts or skips the shifted sample and
// flags the reserved code (which contributes nothing).
module csd_digit_addsub
    import csd_pkg::*;
#(
    parameter int unsigned PROD_W = 34
) (
    input  logic signed [PROD_W-1:0] prod_i,
    input  logic signed [PROD_W-1:0] xs_i,
    input  logic [1:0]               digit_i,
    output logic signed [PROD_W-1:0] sum_o,
    output logic                     rsvd_o
);

    // Decode the digit and select the partial-product update
    always_comb begin
        sum_o  = prod_i;
        rsvd_o = 1'b0;
        case (digit_i)
            CSD_POS:  sum_o  = prod_i + xs_i;
            CSD_NEG:  sum_o  = prod_i - xs_i;
            CSD_RSVD: rsvd_o = 1'b1;
            default:  sum_o  = prod_i;
        endcase
    end

endmodule

// File: rtl/csd_shift_add_mac.sv
// Serial CSD multiply-accumulate: one digit per cycle into a product
// register, then a single signed accumulate with sticky overflow/error.
module csd_shift_add_mac
    import csd_pkg::*;
#(
    parameter int unsigned DATA_W = CSD_DATA_W,
    parameter int unsigned DIGITS = CSD_DIGITS,
    parameter int unsigned ACC_W  = 40
) (
    input  logic                clk,
    input  logic                rst_n,
    csd_shift_add_mac_if.slave  bus
);

    localparam int unsigned PROD_W = DATA_W + DIGITS + 1;
    localparam int unsigned KW     = $clog2(DIGITS + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_ACC  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [KW-1:0]            k_q, k_d;
    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic signed [PROD_W-1:0] x_q, x_d;
    logic [2*DIGITS-1:0]      csd_q, csd_d;
    logic                     clr_q, clr_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     ovf_q, ovf_d;
    logic                     err_q, err_d;

    logic [1:0]               digit;
    logic signed [PROD_W-1:0] xsh;
    logic signed [PROD_W-1:0] step_sum;
    logic                     step_rsvd;
    logic signed [ACC_W-1:0]  acc_base;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_sum;

    assign digit = csd_q[2*k_q +: 2];
    assign xsh   = x_q <<< k_q;

    csd_digit_addsub #(
        .PROD_W (PROD_W)
    ) u_step (
        .prod_i  (prod_q),
        .xs_i    (xsh),
        .digit_i (digit),
        .sum_o   (step_sum),
        .rsvd_o  (step_rsvd)
    );

    assign acc_base = clr_q ? '0 : acc_q;
    assign prod_ext = ACC_W'(prod_q);
    assign acc_sum  = acc_base + prod_ext;

    // Next-state logic: capture, per-digit step, accumulate, done pulse.
    // The accumulate takes its own cycle after the last digit so that done
    // and the new acc_out appear together, one cycle before ready returns.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        prod_d  = prod_q;
        x_d     = x_q;
        csd_d   = csd_q;
        clr_d   = clr_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    x_d     = PROD_W'(bus.x);
                    csd_d   = bus.csd;
                    clr_d   = bus.acc_clr;
                    prod_d  = '0;
                    k_d     = '0;
                    state_d = ST_RUN;
                    if (bus.acc_clr) begin
                        ovf_d = 1'b0;
                        err_d = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                prod_d = step_sum;
                if (step_rsvd) err_d = 1'b1;
                k_d = k_q + 1'b1;
                if (k_q == KW'(DIGITS - 1)) state_d = ST_ACC;
            end
            ST_ACC: begin
                acc_d = acc_sum;
                if ((acc_base[ACC_W-1] == prod_ext[ACC_W-1]) &&
                    (acc_sum[ACC_W-1] != acc_base[ACC_W-1]))
                    ovf_d = 1'b1;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            prod_q  <= '0;
            x_q     <= '0;
            csd_q   <= '0;
            clr_q   <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            prod_q  <= prod_d;
            x_q     <= x_d;
            csd_q   <= csd_d;
            clr_q   <= clr_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign bus.ready   = (state_q == ST_IDLE);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.acc_out = acc_q;
    assign bus.ovf     = ovf_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_csd_shift_add_mac.sv
// Bench for csd_shift_add_mac: a 40-bit and a 34-bit accumulator lane share
// the same stimulus; expected results are queued at acceptance and checked
// when done pulses.
module tb_csd_shift_add_mac;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic signed [15:0] x = '0;
    logic [33:0] csd = '0;
    logic acc_clr = 1'b0;

    always #5 clk = ~clk;

    csd_shift_add_mac_if #(.DATA_W(16), .DIGITS(17), .ACC_W(40)) ifa ();
    csd_shift_add_mac_if #(.DATA_W(16), .DIGITS(17), .ACC_W(34)) ifb ();

    assign ifa.start = start;   assign ifb.start = start;
    assign ifa.x = x;           assign ifb.x = x;
    assign ifa.csd = csd;       assign ifb.csd = csd;
    assign ifa.acc_clr = acc_clr; assign ifb.acc_clr = acc_clr;

    csd_shift_add_mac #(.DATA_W(16), .DIGITS(17), .ACC_W(40)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    csd_shift_add_mac #(.DATA_W(16), .DIGITS(17), .ACC_W(34)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    typedef struct {
        logic signed [15:0] x;
        logic [33:0] csd;
        bit clr;
        longint e40;
        longint e34;
        bit ov40;
        bit ov34;
        bit er;
    } vec_t;

    typedef struct {
        longint e40;
        longint e34;
        bit ov40;
        bit ov34;
        bit er;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard: compare both lanes whenever done is seen
    always @(negedge clk) begin
        if (rst_n && (ifa.done || ifb.done)) begin
            chk("done_lanes_agree", longint'(ifb.done), longint'(ifa.done));
            done_cnt++;
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done got=1 exp=0 at %0t", $time);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("acc_out_40", longint'(ifa.acc_out), e.e40);
                chk("acc_out_34", longint'(ifb.acc_out), e.e34);
                chk("ovf_40", longint'(ifa.ovf), longint'(e.ov40));
                chk("ovf_34", longint'(ifb.ovf), longint'(e.ov34));
                chk("err_40", longint'(ifa.err), longint'(e.er));
                chk("err_34", longint'(ifb.err), longint'(e.er));
            end
        end
    end

    // Drive one transaction from a negedge, optionally holding start high
    // through the whole run, and check ready/latency around it.
    task automatic do_op(input vec_t v, input bit hold_start);
        int n;
        bit busy_ok;
        exp_t e;
        n = 0;
        while (!ifa.ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_start", longint'(ifa.ready), 1);
        x = v.x;
        csd = v.csd;
        acc_clr = v.clr;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.e40 = v.e40; e.e34 = v.e34; e.ov40 = v.ov40; e.ov34 = v.ov34; e.er = v.er;
        sbq.push_back(e);
        if (!hold_start) start = 1'b0;
        x = 16'($urandom);
        csd = {2'($urandom), 32'($urandom)};
        acc_clr = 1'($urandom);
        n = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (!ifa.done && ifa.ready) busy_ok = 1'b0;
        end while (!ifa.done && n < 40);
        start = 1'b0;
        chk("ready_low_while_busy", longint'(busy_ok), 1);
        chk("latency_edges", longint'(n - 1), 18);
        if (!ifa.done && sbq.size() > 0) void'(sbq.pop_front());
        @(negedge clk);
        chk("ready_after_done", longint'(ifa.ready), 1);
    endtask

    vec_t vt[17];

    initial begin
        int dc;
        vec_t v;

        vt[0]  = '{16'sd5,     34'h0_0000_0043, 1'b1, 35, 35, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{-16'sd3,    34'h0_0000_0001, 1'b0, 32, 32, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{-16'sd3,    34'h0_0000_0001, 1'b1, -3, -3, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{16'sd4,     34'h0_0000_0006, 1'b1, 8, 8, 1'b0, 1'b0, 1'b1};
        vt[4]  = '{16'sd1,     34'h0_0000_0001, 1'b0, 9, 9, 1'b0, 1'b0, 1'b1};
        vt[5]  = '{16'sd7,     34'h0_0000_0001, 1'b1, 7, 7, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{16'sd100,   34'h0_0000_0000, 1'b0, 7, 7, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{-16'sd1,    34'h0_0000_0003, 1'b0, 8, 8, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{16'sd32767, 34'h3_0000_0000, 1'b1, -64'sd2147418112, -64'sd2147418112, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{16'sh8000,  34'h1_0000_0000, 1'b1, -64'sd2147483648, -64'sd2147483648, 1'b0, 1'b0, 1'b0};
        vt[10] = '{16'sh8000,  34'h1_0000_0000, 1'b0, -64'sd4294967296, -64'sd4294967296, 1'b0, 1'b0, 1'b0};
        vt[11] = '{16'sh8000,  34'h1_0000_0000, 1'b0, -64'sd6442450944, -64'sd6442450944, 1'b0, 1'b0, 1'b0};
        vt[12] = '{16'sh8000,  34'h1_0000_0000, 1'b0, -64'sd8589934592, -64'sd8589934592, 1'b0, 1'b0, 1'b0};
        vt[13] = '{16'sh8000,  34'h1_0000_0000, 1'b0, -64'sd10737418240, 64'sd6442450944, 1'b0, 1'b1, 1'b0};
        vt[14] = '{16'sd1,     34'h0_0000_0001, 1'b0, -64'sd10737418239, 64'sd6442450945, 1'b0, 1'b1, 1'b0};
        vt[15] = '{16'sd2,     34'h0_0000_0001, 1'b1, 2, 2, 1'b0, 1'b0, 1'b0};
        vt[16] = '{-16'sd5,    34'h0_0000_0039, 1'b0, 17, 17, 1'b0, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset_ready", longint'(ifa.ready), 1);
        chk("reset_done", longint'(ifa.done), 0);
        chk("reset_acc", longint'(ifa.acc_out), 0);
        chk("reset_ovf", longint'(ifa.ovf), 0);
        chk("reset_err", longint'(ifa.err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 17; i++) do_op(vt[i], 1'b0);

        // start held high through the run: exactly one done, result 17+3
        dc = done_cnt;
        v = '{16'sd3, 34'h0_0000_0001, 1'b0, 20, 20, 1'b0, 1'b0, 1'b1};
        do_op(v, 1'b1);
        repeat (30) @(negedge clk);
        chk("single_done_under_start_spam", longint'(done_cnt - dc), 1);

        // reset in the middle of a run
        x = 16'sd9; csd = 34'h1; acc_clr = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_ready", longint'(ifa.ready), 1);
        chk("midrun_reset_acc40", longint'(ifa.acc_out), 0);
        chk("midrun_reset_acc34", longint'(ifb.acc_out), 0);
        chk("midrun_reset_err", longint'(ifa.err), 0);
        chk("midrun_reset_done", longint'(ifa.done), 0);
        dc = done_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("no_done_after_abort", longint'(done_cnt - dc), 0);
        v = '{16'sd1, 34'h0_0000_0001, 1'b1, 1, 1, 1'b0, 1'b0, 1'b0};
        do_op(v, 1'b0);

        chk("scoreboard_drained", longint'(sbq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
